uart_rx: RTL and testbench

Serial receiver for the MIPS_UART subsystem and the far end of the existing UART transmitter. It samples an asynchronous `rx` line and recovers 1 start bit, 8 data bits (LSB first), an optional even-parity bit and 1 stop bit. It presents each received byte with a one-cycle valid pulse and error flags for the processor-side logic.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_bit_timer.sv | 29 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_IDLE
   } uart_rx_state_t;

   localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 10420;
   localparam int unsigned UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Loadable bit-period down-counter; expire pulses while enabled at count==1.
module uart_rx_bit_timer #(
   parameter int unsigned WIDTH = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enable,
   input  logic [WIDTH-1:0] load_val,
   output logic             expire
);

   logic [WIDTH-1:0] r_count;

   // Decrement wraps through zero, so a load value of 2**WIDTH (truncated to 0)
   // still yields a full 2**WIDTH-cycle period.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (enable) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign expire = enable && (r_count == WIDTH'(1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
   parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int unsigned TW  = $clog2(CLKS_PER_BIT);
   localparam int unsigned BCW = $clog2(DATA_BITS);
   localparam logic [TW-1:0]  LOAD_HALF = TW'(CLKS_PER_BIT / 2);
   localparam logic [TW-1:0]  LOAD_FULL = TW'(CLKS_PER_BIT);
   localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);

   uart_rx_state_t       r_state;
   logic [1:0]           r_sync;
   logic [DATA_BITS-1:0] r_shift;
   logic [BCW-1:0]       r_bit_cnt;
   logic                 w_rx_s;
   logic                 w_load;
   logic                 w_enable;
   logic [TW-1:0]        w_load_val;
   logic                 w_expire;
`ifdef UART_RX_PARITY_EN
   logic                 r_par_bit;
`endif

   assign w_rx_s = r_sync[1];
   assign busy   = (r_state != ST_IDLE);

   always_comb begin
      w_load     = 1'b0;
      w_load_val = LOAD_FULL;
      w_enable   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_rx_s) begin
               w_load     = 1'b1;
               w_load_val = LOAD_HALF;
            end
         end
         ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
            w_enable = 1'b1;
            w_load   = w_expire;
         end
         default: ;
      endcase
   end

   uart_rx_bit_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .enable   (w_enable),
      .load_val (w_load_val),
      .expire   (w_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_sync    <= 2'b11;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit  <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         r_sync   <= {r_sync[0], rx};
         rx_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_rx_s) begin
                  r_state   <= ST_START;
                  r_bit_cnt <= '0;
               end
            end
            ST_START: begin
               if (w_expire) begin
                  r_state <= w_rx_s ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_expire) begin
                  r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= ST_PARITY;
`else
                     r_state <= ST_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (w_expire) begin
                  r_par_bit <= w_rx_s;
                  r_state   <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (w_expire) begin
                  rx_data   <= r_shift;
                  rx_valid  <= 1'b1;
                  frame_err <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                  parity_err <= r_par_bit ^ (^r_shift);
`endif
                  // A low stop bit may be a line break; hold off until rx idles.
                  r_state <= w_rx_s ? ST_IDLE : ST_WAIT_IDLE;
               end
            end
            ST_WAIT_IDLE: begin
               if (w_rx_s) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT=16); follows UART_RX_PARITY_EN.
module tb_uart_rx;

   localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam bit          PAR_EN     = 1'b1;
   localparam int unsigned FRAME_BITS = 11;
`else
   localparam bit          PAR_EN     = 1'b0;
   localparam int unsigned FRAME_BITS = 10;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      int         cyc;
   } pulse_t;

   pulse_t q_pulse[$];
   int     cyc = 0;
   int     n_cmp = 0;
   int     n_err = 0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rx_valid) q_pulse.push_back('{rx_data, parity_err, frame_err, cyc});
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: even parity means data plus parity bit carries an even count of ones.
   function automatic logic ref_perr(input logic [7:0] d, input logic par);
      if (!PAR_EN) return 1'b0;
      return (($countones(d) + int'(par)) % 2) == 1;
   endfunction

   function automatic logic even_par(input logic [7:0] d);
      return ($countones(d) % 2) == 1;
   endfunction

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (PAR_EN) drive_bit(par);
      drive_bit(stop);
   endtask

   task automatic expect_frame(input string name, input logic [7:0] d,
                               input logic perr, input logic ferr);
      pulse_t p;
      check({name, ".npulse"}, q_pulse.size(), 1);
      if (q_pulse.size() > 0) begin
         p = q_pulse.pop_front();
         check({name, ".data"}, p.data, d);
         check({name, ".perr"}, p.perr, perr);
         check({name, ".ferr"}, p.ferr, ferr);
      end
      check({name, ".held"}, rx_data, d);
      q_pulse.delete();
   endtask

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      logic       exp_perr_pe;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [7:0] d;
      logic       p;
      pulse_t     pa;
      pulse_t     pb;
      bit         seen;
      int         t_busy;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};

      repeat (4) @(negedge clk);
      rst = 1'b0;
      check("reset.rx_data",    rx_data,    0);
      check("reset.rx_valid",   rx_valid,   0);
      check("reset.parity_err", parity_err, 0);
      check("reset.frame_err",  frame_err,  0);
      check("reset.busy",       busy,       0);
      repeat (4) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
         repeat (3) @(negedge clk);
         expect_frame($sformatf("vec%0d", i), vecs[i].data,
                      PAR_EN ? vecs[i].exp_perr_pe : 1'b0, vecs[i].exp_ferr);
         check($sformatf("vec%0d.busy", i), busy, 0);
      end

      // Break: low stop bit followed by a long low line must yield one frame only.
      send_frame(8'h3C, even_par(8'h3C), 1'b0);
      repeat (40) @(negedge clk);
      expect_frame("break", 8'h3C, 1'b0, 1'b1);
      check("break.busy_low_line", busy, 1);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      check("break.busy_after", busy, 0);
      repeat (20) @(negedge clk);
      check("break.no_extra", q_pulse.size(), 0);

      // Glitch: 4-cycle low is a false start.
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      seen = 1'b0;
      t_busy = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy) seen = 1'b1;
         if (seen && !busy) break;
         t_busy++;
         @(negedge clk);
      end
      check("glitch.seen_busy", seen, 1);
      check("glitch.busy_low_in_time", (seen && !busy) ? 1 : 0, 1);
      repeat (10) @(negedge clk);
      check("glitch.no_pulse", q_pulse.size(), 0);

      // Back-to-back frames with no idle gap.
      send_frame(8'h55, even_par(8'h55), 1'b1);
      send_frame(8'hAA, even_par(8'hAA), 1'b1);
      repeat (3) @(negedge clk);
      check("b2b.npulse", q_pulse.size(), 2);
      if (q_pulse.size() == 2) begin
         pa = q_pulse.pop_front();
         pb = q_pulse.pop_front();
         check("b2b.data0", pa.data, 8'h55);
         check("b2b.data1", pb.data, 8'hAA);
         check("b2b.spacing", pb.cyc - pa.cyc, FRAME_BITS * CPB);
      end
      q_pulse.delete();

      // Reset in the middle of data bit 4 of 0xFF.
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      rx = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("midrst.rx_data",    rx_data,    0);
      check("midrst.parity_err", parity_err, 0);
      check("midrst.frame_err",  frame_err,  0);
      check("midrst.busy",       busy,       0);
      repeat (CPB * FRAME_BITS) @(negedge clk);
      check("midrst.no_pulse", q_pulse.size(), 0);
      send_frame(8'h12, even_par(8'h12), 1'b1);
      repeat (3) @(negedge clk);
      expect_frame("after_rst", 8'h12, 1'b0, 1'b0);

      // Randomised frames against the reference model.
      for (int i = 0; i < 24; i++) begin
         d = 8'($urandom);
         p = 1'($urandom);
         send_frame(d, p, 1'b1);
         repeat (3) @(negedge clk);
         expect_frame($sformatf("rnd%0d", i), d, ref_perr(d, p), 1'b0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
